// File: rtl/rename_register_file.sv
// Architectural register file with one ROB rename tag per register, N read / M commit ports.
// Define RF_COMMIT_BYPASS_EN to forward same-cycle commits onto the read ports.
module rename_register_file #(
    parameter int XLEN             = 32,
    parameter int ROB_TAG_WIDTH    = 4,
    parameter int NUM_READ_PORTS   = 2,
    parameter int NUM_COMMIT_PORTS = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_READ_PORTS*5-1:0]             rs_index,
    output logic [NUM_READ_PORTS*XLEN-1:0]          rs_data,
    output logic [NUM_READ_PORTS*ROB_TAG_WIDTH-1:0] rs_rob_tag,
    output logic [NUM_READ_PORTS-1:0]               rs_rob_tag_valid,
    input  logic                                    alloc_en,
    input  logic [4:0]                              alloc_rd_index,
    input  logic [ROB_TAG_WIDTH-1:0]                alloc_tag,
    input  logic [NUM_COMMIT_PORTS-1:0]             commit_en,
    input  logic [NUM_COMMIT_PORTS*5-1:0]           commit_rd_index,
    input  logic [NUM_COMMIT_PORTS*ROB_TAG_WIDTH-1:0] commit_rob_tag,
    input  logic [NUM_COMMIT_PORTS*XLEN-1:0]        commit_data,
    input  logic                                    flush
);

    logic [XLEN-1:0]          data_q  [32];
    logic [XLEN-1:0]          data_d  [32];
    logic [ROB_TAG_WIDTH-1:0] tag_q   [32];
    logic [ROB_TAG_WIDTH-1:0] tag_d   [32];
    logic [31:0]              valid_q;
    logic [31:0]              valid_d;
    logic [31:0]              clear;

    logic [4:0]               c_rd   [NUM_COMMIT_PORTS];
    logic [ROB_TAG_WIDTH-1:0] c_tag  [NUM_COMMIT_PORTS];
    logic [XLEN-1:0]          c_data [NUM_COMMIT_PORTS];
    logic [4:0]               r_idx  [NUM_READ_PORTS];

    for (genvar p = 0; p < NUM_COMMIT_PORTS; p++) begin : g_commit_unpack
        assign c_rd[p]   = commit_rd_index[5*p +: 5];
        assign c_tag[p]  = commit_rob_tag[ROB_TAG_WIDTH*p +: ROB_TAG_WIDTH];
        assign c_data[p] = commit_data[XLEN*p +: XLEN];
    end

    for (genvar rp = 0; rp < NUM_READ_PORTS; rp++) begin : g_read_unpack
        assign r_idx[rp] = rs_index[5*rp +: 5];
    end

    // Ports are walked in ascending order so the youngest commit's data lands last.
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        clear   = '0;
        for (int p = 0; p < NUM_COMMIT_PORTS; p++) begin
            if (commit_en[p] && (c_rd[p] != 5'd0)) begin
                data_d[c_rd[p]] = c_data[p];
                if (valid_q[c_rd[p]] && (c_tag[p] == tag_q[c_rd[p]])) begin
                    clear[c_rd[p]] = 1'b1;
                end
            end
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) begin
                tag_d[r] = '0;
            end
            valid_d = '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (clear[r]) begin
                    tag_d[r]   = '0;
                    valid_d[r] = 1'b0;
                end
            end
            // A fresh rename outranks a clear from the commit of an older producer.
            if (alloc_en && (alloc_rd_index != 5'd0)) begin
                tag_d[alloc_rd_index]   = alloc_tag;
                valid_d[alloc_rd_index] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q  <= data_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        rs_data          = '0;
        rs_rob_tag       = '0;
        rs_rob_tag_valid = '0;
        for (int rp = 0; rp < NUM_READ_PORTS; rp++) begin
            if (r_idx[rp] != 5'd0) begin
                rs_data[XLEN*rp +: XLEN]                   = data_q[r_idx[rp]];
                rs_rob_tag[ROB_TAG_WIDTH*rp +: ROB_TAG_WIDTH] = tag_q[r_idx[rp]];
                rs_rob_tag_valid[rp]                       = valid_q[r_idx[rp]];
`ifdef RF_COMMIT_BYPASS_EN
                // Later (younger) matching ports overwrite earlier ones, including the tag view.
                for (int p = 0; p < NUM_COMMIT_PORTS; p++) begin
                    if (commit_en[p] && (c_rd[p] == r_idx[rp])) begin
                        rs_data[XLEN*rp +: XLEN] = c_data[p];
                        if (valid_q[r_idx[rp]] && (c_tag[p] == tag_q[r_idx[rp]])) begin
                            rs_rob_tag[ROB_TAG_WIDTH*rp +: ROB_TAG_WIDTH] = '0;
                            rs_rob_tag_valid[rp]                       = 1'b0;
                        end else begin
                            rs_rob_tag[ROB_TAG_WIDTH*rp +: ROB_TAG_WIDTH] = tag_q[r_idx[rp]];
                            rs_rob_tag_valid[rp]                       = valid_q[r_idx[rp]];
                        end
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rename_register_file.sv
// Randomised self-checking bench for rename_register_file against an array-based model.
// Honours RF_COMMIT_BYPASS_EN in its read expectations.
module tb_rename_register_file;

    localparam int XLEN = 32;
    localparam int TW   = 4;
    localparam int NR   = 2;
    localparam int NC   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*5-1:0]   rs_index;
    logic [NR*XLEN-1:0] rs_data;
    logic [NR*TW-1:0]  rs_rob_tag;
    logic [NR-1:0]     rs_rob_tag_valid;
    logic              alloc_en;
    logic [4:0]        alloc_rd_index;
    logic [TW-1:0]     alloc_tag;
    logic [NC-1:0]     commit_en;
    logic [NC*5-1:0]   commit_rd_index;
    logic [NC*TW-1:0]  commit_rob_tag;
    logic [NC*XLEN-1:0] commit_data;
    logic              flush;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] m_data  [32];
    logic [TW-1:0]   m_tag   [32];
    logic            m_valid [32];

    rename_register_file #(
        .XLEN(XLEN), .ROB_TAG_WIDTH(TW), .NUM_READ_PORTS(NR), .NUM_COMMIT_PORTS(NC)
    ) dut (
        .clk(clk), .reset(reset), .rs_index(rs_index), .rs_data(rs_data),
        .rs_rob_tag(rs_rob_tag), .rs_rob_tag_valid(rs_rob_tag_valid),
        .alloc_en(alloc_en), .alloc_rd_index(alloc_rd_index), .alloc_tag(alloc_tag),
        .commit_en(commit_en), .commit_rd_index(commit_rd_index),
        .commit_rob_tag(commit_rob_tag), .commit_data(commit_data), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_data[r] = '0; m_tag[r] = '0; m_valid[r] = 1'b0;
        end
    endtask

    task automatic set_idle();
        alloc_en = 1'b0; alloc_rd_index = '0; alloc_tag = '0;
        commit_en = '0; commit_rd_index = '0; commit_rob_tag = '0; commit_data = '0;
        flush = 1'b0; rs_index = '0;
    endtask

    task automatic do_commit(int p, logic [4:0] rd, logic [TW-1:0] tag, logic [XLEN-1:0] d);
        commit_en[p] = 1'b1;
        commit_rd_index[5*p +: 5] = rd;
        commit_rob_tag[TW*p +: TW] = tag;
        commit_data[XLEN*p +: XLEN] = d;
    endtask

    task automatic do_alloc(logic [4:0] rd, logic [TW-1:0] tag);
        alloc_en = 1'b1; alloc_rd_index = rd; alloc_tag = tag;
    endtask

    task automatic set_read(int rp, logic [4:0] idx);
        rs_index[5*rp +: 5] = idx;
    endtask

    // Compare both read ports against the model's view given the inputs now applied.
    task automatic check_reads(string name);
        logic [4:0]      idx;
        logic [XLEN-1:0] ed;
        logic [TW-1:0]   et;
        logic            ev;
        #1;
        for (int rp = 0; rp < NR; rp++) begin
            idx = rs_index[5*rp +: 5];
            ed = '0; et = '0; ev = 1'b0;
            if (idx != 0) begin
                ed = m_data[idx]; et = m_tag[idx]; ev = m_valid[idx];
`ifdef RF_COMMIT_BYPASS_EN
                for (int p = 0; p < NC; p++) begin
                    if (commit_en[p] && commit_rd_index[5*p +: 5] == idx) begin
                        ed = commit_data[XLEN*p +: XLEN];
                        if (m_valid[idx] && commit_rob_tag[TW*p +: TW] == m_tag[idx]) begin
                            et = '0; ev = 1'b0;
                        end else begin
                            et = m_tag[idx]; ev = m_valid[idx];
                        end
                    end
                end
`endif
            end
            check_val({name, "_data"}, rs_data[XLEN*rp +: XLEN], ed);
            check_val({name, "_tag"}, 32'(rs_rob_tag[TW*rp +: TW]), 32'(et));
            check_val({name, "_valid"}, 32'(rs_rob_tag_valid[rp]), 32'(ev));
        end
    endtask

    // Apply the current inputs across one rising edge and advance the model.
    task automatic step();
        logic [XLEN-1:0] nd [32];
        logic [TW-1:0]   nt [32];
        logic            nv [32];
        logic            clr [32];
        logic [4:0]      rd;
        nd = m_data; nt = m_tag; nv = m_valid;
        for (int r = 0; r < 32; r++) clr[r] = 1'b0;
        for (int p = 0; p < NC; p++) begin
            rd = commit_rd_index[5*p +: 5];
            if (commit_en[p] && rd != 0) begin
                nd[rd] = commit_data[XLEN*p +: XLEN];
                if (m_valid[rd] && commit_rob_tag[TW*p +: TW] == m_tag[rd]) clr[rd] = 1'b1;
            end
        end
        if (flush) begin
            for (int r = 0; r < 32; r++) begin
                nt[r] = '0; nv[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (clr[r]) begin
                    nt[r] = '0; nv[r] = 1'b0;
                end
            end
            if (alloc_en && alloc_rd_index != 0) begin
                nt[alloc_rd_index] = alloc_tag; nv[alloc_rd_index] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_data = nd; m_tag = nt; m_valid = nv;
    endtask

    initial begin
        logic [4:0] rd;
        model_reset();
        set_idle();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        @(posedge clk); #1;
        set_read(0, 5'd7); set_read(1, 5'd31);
        check_reads("reset_state");

        // x7 <= 0x1234 renamed to tag 5, then asynchronous reset mid-cycle
        set_idle(); do_commit(0, 5'd7, 4'h0, 32'h1234); step();
        set_idle(); do_alloc(5'd7, 4'h5); step();
        set_idle(); set_read(0, 5'd7);
        check_reads("x7_setup");
        check_val("x7_pre_data", rs_data[31:0], 32'h1234);
        check_val("x7_pre_valid", 32'(rs_rob_tag_valid[0]), 32'd1);
        reset = 1'b1;
        #1;
        check_val("async_rst_data", rs_data[31:0], 32'h0);
        check_val("async_rst_tag", 32'(rs_rob_tag[3:0]), 32'h0);
        check_val("async_rst_valid", 32'(rs_rob_tag_valid[0]), 32'h0);
        model_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;

        // Older commit leaves the rename intact, matching commit clears it
        set_idle(); do_alloc(5'd3, 4'hB); step();
        set_idle(); do_commit(0, 5'd3, 4'h9, 32'h01234567); step();
        set_idle(); set_read(0, 5'd3);
        check_reads("older_commit");
        check_val("t2_data", rs_data[31:0], 32'h01234567);
        check_val("t2_tag", 32'(rs_rob_tag[3:0]), 32'hB);
        set_idle(); do_commit(1, 5'd3, 4'hB, 32'h89ABCDEF); step();
        set_idle(); set_read(0, 5'd3);
        check_reads("match_commit");
        check_val("t2b_valid", 32'(rs_rob_tag_valid[0]), 32'h0);

        // Allocation beats same-cycle tag clear
        set_idle(); do_alloc(5'd5, 4'hF); step();
        set_idle(); do_commit(0, 5'd5, 4'hF, 32'hAAAABBBB); do_alloc(5'd5, 4'h2); step();
        set_idle(); set_read(1, 5'd5);
        check_reads("alloc_over_clear");
        check_val("t3_tag", 32'(rs_rob_tag[7:4]), 32'h2);

        // Same rd on both commit ports: port 1 wins
        set_idle(); do_commit(0, 5'd9, 4'h0, 32'h11); do_commit(1, 5'd9, 4'h0, 32'h22); step();
        set_idle(); set_read(0, 5'd9);
        check_reads("dual_commit");
        check_val("t4_data", rs_data[31:0], 32'h22);

        // Flush drops renames and same-cycle alloc, keeps commit data
        set_idle(); do_alloc(5'd4, 4'h3); step();
        set_idle(); do_alloc(5'd6, 4'h7); step();
        set_idle(); flush = 1'b1; do_alloc(5'd8, 4'h1); do_commit(0, 5'd4, 4'h0, 32'h55); step();
        set_idle(); set_read(0, 5'd4); set_read(1, 5'd6);
        check_reads("flush_a");
        check_val("t5_x4_data", rs_data[31:0], 32'h55);
        set_read(0, 5'd8);
        check_reads("flush_b");
        check_val("t5_x8_valid", 32'(rs_rob_tag_valid[0]), 32'h0);

        // x0 is hardwired
        set_idle(); do_alloc(5'd0, 4'h4); do_commit(0, 5'd0, 4'h4, 32'hFFFF); step();
        set_idle();
        check_reads("x0");
`ifdef RF_COMMIT_BYPASS_EN
        set_idle(); do_commit(0, 5'd10, 4'h0, 32'h77); set_read(0, 5'd10);
        check_reads("bypass");
        check_val("t6_bypass_data", rs_data[31:0], 32'h77);
        step();
`endif

        // Random traffic over a small register window to force collisions
        for (int n = 0; n < 400; n++) begin
            set_idle();
            for (int p = 0; p < NC; p++) begin
                if ($urandom_range(1, 0) == 1) begin
                    rd = 5'($urandom_range(7, 0));
                    do_commit(p, rd,
                              ($urandom_range(1, 0) == 1) ? m_tag[rd] : TW'($urandom_range(15, 0)),
                              $urandom());
                end
            end
            if ($urandom_range(1, 0) == 1)
                do_alloc(5'($urandom_range(7, 0)), TW'($urandom_range(15, 0)));
            flush = ($urandom_range(15, 0) == 0);
            set_read(0, 5'($urandom_range(7, 0)));
            set_read(1, 5'($urandom_range(7, 0)));
            check_reads("rnd");
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
